// File: rtl/bram_bus_slave.sv
// rtl/bram_bus_slave.sv - serial bus slave driving port A of a 4096x8 block RAM
//
// Purpose:
//   Receives a serial transaction from the bus master (mode bit, then address
//   and optional write data, all LSB first), performs one single-cycle BRAM
//   access, and for reads shifts the returned byte back out LSB first.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   s_valid    - master request, sampled only while idle
//   s_mode     - 1 = write, 0 = read, sampled with s_valid
//   s_sdin     - serial address / write-data bit, LSB first
//   s_ready    - slave idle and BRAM not busy (combinational)
//   s_rvalid   - s_sdout carries a read-data bit
//   s_sdout    - serial read-data bit, LSB first
//   s_done     - one-cycle completion pulse
//   bram_addr  - BRAM port-A address (holds between transactions)
//   bram_din   - BRAM port-A write data (holds between transactions)
//   bram_dout  - BRAM port-A read data
//   bram_en    - BRAM port-A enable
//   bram_we    - BRAM port-A write enable
//   bram_busy  - BRAM reset-busy; no access may be issued while high

module bram_bus_slave #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic              s_mode,
    input  logic              s_sdin,
    output logic              s_ready,
    output logic              s_rvalid,
    output logic              s_sdout,
    output logic              s_done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              bram_en,
    output logic              bram_we,
    input  logic              bram_busy
);

    localparam int SHIFT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W     = $clog2(SHIFT_MAX);
    localparam int LAT_W     = 2;

    typedef enum logic [3:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        HOLD,
        MEM_WR,
        MEM_RD,
        RD_WAIT,
        TX,
        DONE
    } state_t;

    state_t             state;
    logic               mode;
    logic [CNT_W-1:0]   bit_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [ADDR_W-1:0]  addr_sr;
    logic [DATA_W-1:0]  wdata_sr;
    logic [DATA_W-1:0]  tx_sr;

    // Shift-register contents including the bit arriving this cycle, so the
    // access can be launched straight from the last receive cycle.
    logic [ADDR_W-1:0]  addr_next;
    logic [DATA_W-1:0]  wdata_next;

    assign addr_next  = {s_sdin, addr_sr[ADDR_W-1:1]};
    assign wdata_next = {s_sdin, wdata_sr[DATA_W-1:1]};

    // State is forced to IDLE during reset, so reset must gate ready explicitly.
    assign s_ready = reset && (state == IDLE) && !bram_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mode      <= 1'b0;
            bit_cnt   <= '0;
            lat_cnt   <= '0;
            addr_sr   <= '0;
            wdata_sr  <= '0;
            tx_sr     <= '0;
            s_rvalid  <= 1'b0;
            s_sdout   <= 1'b0;
            s_done    <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
        end else begin
            // Pulsed outputs fall back to zero unless a state re-asserts them.
            s_done   <= 1'b0;
            s_rvalid <= 1'b0;
            s_sdout  <= 1'b0;
            bram_en  <= 1'b0;
            bram_we  <= 1'b0;

            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        mode    <= s_mode;
                        bit_cnt <= '0;
                        state   <= RX_ADDR;
                    end
                end

                RX_ADDR: begin
                    addr_sr <= addr_next;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                        bit_cnt <= '0;
                        if (mode) begin
                            state <= RX_DATA;
                        end else if (!bram_busy) begin
                            // HOLD collapses to nothing when the BRAM is free.
                            bram_en   <= 1'b1;
                            bram_addr <= addr_next;
                            state     <= MEM_RD;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end

                RX_DATA: begin
                    wdata_sr <= wdata_next;
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        bit_cnt <= '0;
                        if (!bram_busy) begin
                            bram_en   <= 1'b1;
                            bram_we   <= 1'b1;
                            bram_addr <= addr_sr;
                            bram_din  <= wdata_next;
                            state     <= MEM_WR;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (!bram_busy) begin
                        bram_en   <= 1'b1;
                        bram_we   <= mode;
                        bram_addr <= addr_sr;
                        if (mode) begin
                            bram_din <= wdata_sr;
                        end
                        state <= mode ? MEM_WR : MEM_RD;
                    end
                end

                MEM_WR: begin
                    s_done <= 1'b1;
                    state  <= DONE;
                end

                MEM_RD: begin
                    lat_cnt <= '0;
                    state   <= RD_WAIT;
                end

                RD_WAIT: begin
                    // One RD_WAIT cycle per unit of read latency; dout is
                    // sampled on the last one and its LSB goes out next cycle.
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    if (lat_cnt == LAT_W'(RD_LATENCY - 1)) begin
                        tx_sr    <= bram_dout;
                        s_sdout  <= bram_dout[0];
                        s_rvalid <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= TX;
                    end
                end

                TX: begin
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        s_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        tx_sr    <= tx_sr >> 1;
                        s_sdout  <= tx_sr[1];
                        s_rvalid <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_bus_slave.sv
// tb/tb_bram_bus_slave.sv - bench for bram_bus_slave at read latencies 1 and 2

module tb_bram_bus_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  valid_v, mode_v, sdin_v, busy_v;
    logic [1:0]  ready_v, rvalid_v, sdout_v, done_v, en_v, we_v;
    logic [11:0] addr_o [2];
    logic [7:0]  din_o  [2];
    logic [7:0]  dout_i [2];

    int n_tests = 0;
    int n_fail  = 0;

    bram_bus_slave #(.ADDR_W(12), .DATA_W(8), .RD_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .s_valid(valid_v[0]), .s_mode(mode_v[0]), .s_sdin(sdin_v[0]),
        .s_ready(ready_v[0]), .s_rvalid(rvalid_v[0]), .s_sdout(sdout_v[0]), .s_done(done_v[0]),
        .bram_addr(addr_o[0]), .bram_din(din_o[0]), .bram_dout(dout_i[0]),
        .bram_en(en_v[0]), .bram_we(we_v[0]), .bram_busy(busy_v[0])
    );

    bram_bus_slave #(.ADDR_W(12), .DATA_W(8), .RD_LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .s_valid(valid_v[1]), .s_mode(mode_v[1]), .s_sdin(sdin_v[1]),
        .s_ready(ready_v[1]), .s_rvalid(rvalid_v[1]), .s_sdout(sdout_v[1]), .s_done(done_v[1]),
        .bram_addr(addr_o[1]), .bram_din(din_o[1]), .bram_dout(dout_i[1]),
        .bram_en(en_v[1]), .bram_we(we_v[1]), .bram_busy(busy_v[1])
    );

    // BRAM models: dout lags a read enable by one (p0) or two (p1) cycles.
    logic [7:0] mem [2][4096];
    logic [7:0] p0 [2];
    logic [7:0] p1 [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (en_v[d]) begin
                if (we_v[d]) mem[d][addr_o[d]] <= din_o[d];
                else         p0[d] <= mem[d][addr_o[d]];
            end
            p1[d] <= p0[d];
        end
    end

    assign dout_i[0] = p0[0];
    assign dout_i[1] = p1[1];

    // Scoreboard: what each memory should hold after the transactions issued.
    logic [7:0] refm    [2][4096];
    bit         written [2][4096];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete bus transaction on DUT d, with optional busy window
    // [busy_on, busy_off) in cycle numbers counted from the accept cycle T0.
    task automatic txn(input int d, input bit wr, input logic [11:0] a, input logic [7:0] wd,
                       input int busy_on, input int busy_off, output logic [7:0] rd);
        int   k, guard, en_k, done_k, n_en, n_done, nbits, rvk, lat, base, exp_en, exp_done;
        bit   done_seen;
        logic [7:0] rdv;
        guard = 0;
        while (!ready_v[d] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_txn", 32'(ready_v[d]), 32'd1);
        valid_v[d] = 1'b1;
        mode_v[d]  = wr;
        k = 0; en_k = -1; done_k = -1; n_en = 0; n_done = 0; nbits = 0; rvk = -1;
        rdv = 8'h00; done_seen = 1'b0;
        while (!done_seen && k < 150) begin
            @(negedge clk);
            k++;
            if (k == 1) check("ready_low_in_txn", 32'(ready_v[d]), 32'd0);
            if (en_v[d]) begin
                n_en++;
                en_k = k;
                check("en_addr", 32'(addr_o[d]), 32'(a));
                check("en_we", 32'(we_v[d]), 32'(wr));
                if (wr) check("en_din", 32'(din_o[d]), 32'(wd));
                check("en_while_busy", 32'(busy_v[d]), 32'd0);
            end
            if (we_v[d] && !en_v[d]) check("we_without_en", 32'(en_v[d]), 32'd1);
            if (rvalid_v[d]) begin
                if (rvk < 0) rvk = k;
                if (nbits < 8) rdv[nbits] = sdout_v[d];
                nbits++;
            end
            if (done_v[d]) begin
                n_done++;
                done_k = k;
                done_seen = 1'b1;
            end
            valid_v[d] = 1'b0;
            if (k == busy_on)  busy_v[d] = 1'b1;
            if (k == busy_off) busy_v[d] = 1'b0;
            if (k <= 12)             sdin_v[d] = a[k-1];
            else if (wr && k <= 20)  sdin_v[d] = wd[k-13];
            else                     sdin_v[d] = 1'($urandom_range(0, 1));
        end
        check("txn_completed", 32'(done_seen), 32'd1);
        if (done_seen) begin
            @(negedge clk);
            check("done_single_cycle", 32'(done_v[d]), 32'd0);
            check("ready_after_done", 32'(ready_v[d]), 32'd1);
        end
        sdin_v[d] = 1'b0;
        lat    = (d == 0) ? 1 : 2;
        base   = wr ? 21 : 13;
        exp_en = (busy_on > 0 && busy_on <= base - 1 && busy_off > base - 1) ? busy_off + 1 : base;
        exp_done = wr ? exp_en + 1 : exp_en + 1 + lat + 8;
        check("en_count", n_en, 1);
        check("en_cycle", en_k, exp_en);
        check("done_count", n_done, 1);
        check("done_cycle", done_k, exp_done);
        if (!wr) begin
            check("rvalid_bits", nbits, 8);
            check("rvalid_first_cycle", rvk, exp_en + 1 + lat);
        end
        rd = rdv;
    endtask

    task automatic wr_t(input int d, input logic [11:0] a, input logic [7:0] v,
                        input int bon, input int boff);
        logic [7:0] unused_rd;
        txn(d, 1'b1, a, v, bon, boff, unused_rd);
        refm[d][a]    = v;
        written[d][a] = 1'b1;
    endtask

    task automatic rd_t(input int d, input logic [11:0] a, input int bon, input int boff);
        logic [7:0] r;
        txn(d, 1'b0, a, 8'h00, bon, boff, r);
        check("read_data", 32'(r), 32'(refm[d][a]));
    endtask

    initial begin
        logic [11:0] a;
        logic [11:0] ra;
        reset   = 1'b0;
        valid_v = 2'b00;
        mode_v  = 2'b00;
        sdin_v  = 2'b00;
        busy_v  = 2'b11;
        repeat (2) @(negedge clk);

        // Reset values
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(ready_v[d]), 32'd0);
            check("rst_rvalid", 32'(rvalid_v[d]), 32'd0);
            check("rst_done", 32'(done_v[d]), 32'd0);
            check("rst_en", 32'(en_v[d]), 32'd0);
            check("rst_addr", 32'(addr_o[d]), 32'd0);
            check("rst_din", 32'(din_o[d]), 32'd0);
        end

        // Busy after reset: not ready, requests ignored, ready once busy drops
        reset = 1'b1;
        valid_v = 2'b11;
        mode_v  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_ready_low0", 32'(ready_v[0]), 32'd0);
            check("busy_ready_low1", 32'(ready_v[1]), 32'd0);
        end
        valid_v = 2'b00;
        busy_v  = 2'b00;
        @(negedge clk);
        check("busy_drop_ready0", 32'(ready_v[0]), 32'd1);
        check("busy_drop_ready1", 32'(ready_v[1]), 32'd1);
        check("busy_no_access", 32'(en_v), 32'd0);

        // Basic write/read, 0xAA reads back as alternating 0,1 LSB first
        wr_t(0, 12'h002, 8'hAA, 0, 0);
        rd_t(0, 12'h002, 0, 0);

        // Address boundary, both latencies
        for (int d = 0; d < 2; d++) begin
            wr_t(d, 12'hFFF, 8'h3C, 0, 0);
            wr_t(d, 12'h000, 8'hC3, 0, 0);
            rd_t(d, 12'hFFF, 0, 0);
            rd_t(d, 12'h000, 0, 0);
        end

        // Busy raised during address phase: access waits in HOLD
        wr_t(0, 12'h155, 8'h5A, 5, 30);
        rd_t(0, 12'h155, 0, 0);
        wr_t(1, 12'h2A7, 8'h81, 0, 0);
        rd_t(1, 12'h2A7, 8, 20);

        // Back-to-back writes then reads, both latencies
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) wr_t(d, 12'(12'h010 + i), 8'($urandom), 0, 0);
            for (int i = 0; i < 4; i++) rd_t(d, 12'(12'h010 + i), 0, 0);
        end

        // Random traffic clustered at both ends of the address space
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                a = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 31))
                                                : 12'($urandom_range(4064, 4095));
                if (!written[d][a] || $urandom_range(0, 1) == 1) wr_t(d, a, 8'($urandom), 0, 0);
                else                                            rd_t(d, a, 0, 0);
            end
        end

        // Reset in the middle of the write-data phase
        ra = 12'h0A5;
        wr_t(0, ra, 8'h77, 0, 0);
        valid_v[0] = 1'b1;
        mode_v[0]  = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            valid_v[0] = 1'b0;
            sdin_v[0]  = (k <= 12) ? ra[k-1] : 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ready", 32'(ready_v[0]), 32'd0);
        check("midrst_rvalid", 32'(rvalid_v[0]), 32'd0);
        check("midrst_sdout", 32'(sdout_v[0]), 32'd0);
        check("midrst_done", 32'(done_v[0]), 32'd0);
        check("midrst_en", 32'(en_v[0]), 32'd0);
        check("midrst_we", 32'(we_v[0]), 32'd0);
        check("midrst_addr", 32'(addr_o[0]), 32'd0);
        check("midrst_din", 32'(din_o[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_hold_we", 32'(we_v[0]), 32'd0);
        end
        sdin_v[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        rd_t(0, ra, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
